// File: rtl/traffic_light_controller.sv
// Two-road intersection sequencer: main road rests on green, side road and walk lamp
// are served on demand. All timing advances on a shared one-cycle tick strobe.
module traffic_light_controller #(
  parameter int unsigned MAIN_GREEN_TICKS = 20,
  parameter int unsigned SIDE_GREEN_TICKS = 10,
  parameter int unsigned YELLOW_TICKS     = 3,
  parameter int unsigned ALL_RED_TICKS    = 1,
  parameter int unsigned CNT_W            = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       side_sensor,
  input  logic       ped_req,
  output logic [1:0] main_signal,
  output logic [1:0] side_signal,
  output logic       ped_walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5
  } state_e;

  localparam logic [1:0] SIG_RED    = 2'b00;
  localparam logic [1:0] SIG_YELLOW = 2'b01;
  localparam logic [1:0] SIG_GREEN  = 2'b10;

  localparam logic [CNT_W-1:0] MG_LAST  = CNT_W'(MAIN_GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] SG_LAST  = CNT_W'(SIDE_GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YEL_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ped_pending_q, ped_pending_d;
  logic             walk_flag_q, walk_flag_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= MAIN_GREEN;
      cnt_q         <= '0;
      ped_pending_q <= 1'b0;
      walk_flag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
      walk_flag_q   <= walk_flag_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ped_pending_d = ped_pending_q | ped_req;
    walk_flag_d   = walk_flag_q;

    case (state_q)
      // Counter parks at its last value; the exit waits for demand on a tick.
      MAIN_GREEN: begin
        if (tick) begin
          if (cnt_q == MG_LAST) begin
            if (side_sensor || ped_pending_q) begin
              state_d = MAIN_YELLOW;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      MAIN_YELLOW: begin
        if (tick) begin
          if (cnt_q == YEL_LAST) begin
            state_d = ALL_RED_A;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ALL_RED_A: begin
        if (tick) begin
          if (cnt_q == AR_LAST) begin
            state_d = SIDE_GREEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      SIDE_GREEN: begin
        if (tick) begin
          if (cnt_q == SG_LAST) begin
            state_d = SIDE_YELLOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      SIDE_YELLOW: begin
        if (tick) begin
          if (cnt_q == YEL_LAST) begin
            state_d = ALL_RED_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      ALL_RED_B: begin
        if (tick) begin
          if (cnt_q == AR_LAST) begin
            state_d = MAIN_GREEN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      default: begin
        state_d     = MAIN_GREEN;
        cnt_d       = '0;
        walk_flag_d = 1'b0;
      end
    endcase

    // A request arriving on the entry edge itself is dropped: clear wins.
    if ((state_d == SIDE_GREEN) && (state_q != SIDE_GREEN)) begin
      ped_pending_d = 1'b0;
      walk_flag_d   = ped_pending_q;
    end
    if ((state_q == SIDE_GREEN) && (state_d != SIDE_GREEN)) begin
      walk_flag_d = 1'b0;
    end
  end

  always_comb begin
    main_signal = SIG_RED;
    side_signal = SIG_RED;
    phase       = 3'd0;
    case (state_q)
      MAIN_GREEN: begin
        main_signal = SIG_GREEN;
        phase       = 3'd0;
      end
      MAIN_YELLOW: begin
        main_signal = SIG_YELLOW;
        phase       = 3'd1;
      end
      ALL_RED_A:   phase = 3'd2;
      SIDE_GREEN: begin
        side_signal = SIG_GREEN;
        phase       = 3'd3;
      end
      SIDE_YELLOW: begin
        side_signal = SIG_YELLOW;
        phase       = 3'd4;
      end
      ALL_RED_B:   phase = 3'd5;
      default: begin
        main_signal = SIG_RED;
        side_signal = SIG_RED;
        phase       = 3'd0;
      end
    endcase
  end

  assign ped_walk = walk_flag_q;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller with durations 4/3/2/1 ticks:
// vector table for the basic sequences, hand-written sequences for the timing corners.
module tb_traffic_light_controller;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  typedef struct {
    logic       rst;
    logic       tk;
    logic       ss;
    logic       pr;
    logic [1:0] m;
    logic [1:0] s;
    logic       w;
    logic [2:0] ph;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       side_sensor = 1'b0;
  logic       ped_req = 1'b0;
  logic [1:0] main_signal;
  logic [1:0] side_signal;
  logic       ped_walk;
  logic [2:0] phase;

  int   n_tests = 0;
  int   n_fail = 0;
  int   tick_div = 1;
  int   tcnt = 0;
  logic mon_en = 1'b0;
  vec_t tbl[$];

  traffic_light_controller #(
    .MAIN_GREEN_TICKS(4),
    .SIDE_GREEN_TICKS(3),
    .YELLOW_TICKS    (2),
    .ALL_RED_TICKS   (1),
    .CNT_W           (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .side_sensor(side_sensor),
    .ped_req    (ped_req),
    .main_signal(main_signal),
    .side_signal(side_signal),
    .ped_walk   (ped_walk),
    .phase      (phase)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  // safety invariant, checked every cycle once reset has been applied
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if ((main_signal != R && side_signal != R) || main_signal == 2'b11 ||
          side_signal == 2'b11 || phase > 3'd5) begin
        n_fail++;
        $display("FAIL safety: got main=%b side=%b phase=%0d, required at most one non-red road, no code 11, phase<=5",
                 main_signal, side_signal, phase);
      end
    end
  end

  // driver tasks
  task automatic add(input int n, input logic r, input logic t, input logic s, input logic p,
                     input logic [1:0] m, input logic [1:0] sd, input logic w, input logic [2:0] ph);
    vec_t v;
    v.rst = r; v.tk = t; v.ss = s; v.pr = p;
    v.m = m; v.s = sd; v.w = w; v.ph = ph;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic t, input logic s, input logic p);
    reset = r; tick = t; side_sensor = s; ped_req = p;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  task automatic tstep(input logic s, input logic p);
    logic t;
    t = ((tcnt % tick_div) == 0);
    tcnt++;
    step(1'b0, t, s, p);
  endtask

  task automatic do_reset(input int cycles, input logic s);
    for (int k = 0; k < cycles; k++) step(1'b1, 1'b1, s, 1'b0);
    tcnt = 0;
  endtask

  // scoreboard checks
  task automatic chk(input string nm, input logic [1:0] m, input logic [1:0] sd,
                     input logic w, input logic [2:0] ph);
    n_tests++;
    if ({main_signal, side_signal, ped_walk, phase} !== {m, sd, w, ph}) begin
      n_fail++;
      $display("FAIL %s: got main=%b side=%b walk=%b phase=%0d, expected main=%b side=%b walk=%b phase=%0d",
               nm, main_signal, side_signal, ped_walk, phase, m, sd, w, ph);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic wait_phase(input string nm, input logic [2:0] ph, input logic s);
    int k = 0;
    while (phase !== ph && k < 300) begin
      tstep(s, 1'b0);
      k++;
    end
    n_tests++;
    if (phase !== ph) begin
      n_fail++;
      $display("FAIL %s: timed out waiting for phase %0d, got phase %0d", nm, ph, phase);
    end
  endtask

  // length in cycles of the phase currently showing, counted until it changes
  task automatic run_len(input logic [2:0] ph, input logic s, output int n);
    n = 1;
    for (int k = 0; k < 500; k++) begin
      tstep(s, 1'b0);
      if (phase === ph) n++;
      else break;
    end
  endtask

  initial begin
    int n;

    // idle after reset: rests on main green
    do_reset(3, 1'b0);
    chk("reset_state", G, R, 1'b0, 3'd0);
    for (int k = 0; k < 50; k++) begin
      tstep(1'b0, 1'b0);
      chk("idle_main_green", G, R, 1'b0, 3'd0);
    end

    // side-sensor full cycle (4/2/1/3/2/1 cycles)
    add(1, 1, 1, 1, 0, G, R, 0, 3'd0);
    add(3, 0, 1, 1, 0, G, R, 0, 3'd0);
    add(2, 0, 1, 1, 0, Y, R, 0, 3'd1);
    add(1, 0, 1, 1, 0, R, R, 0, 3'd2);
    add(3, 0, 1, 1, 0, R, G, 0, 3'd3);
    add(2, 0, 1, 1, 0, R, Y, 0, 3'd4);
    add(1, 0, 1, 1, 0, R, R, 0, 3'd5);
    add(4, 0, 1, 1, 0, G, R, 0, 3'd0);
    add(1, 0, 1, 1, 0, Y, R, 0, 3'd1);
    // pedestrian pulse at cycle 10, no side traffic
    add(1, 1, 1, 0, 0, G, R, 0, 3'd0);
    add(9, 0, 1, 0, 0, G, R, 0, 3'd0);
    add(1, 0, 1, 0, 1, G, R, 0, 3'd0);
    add(2, 0, 1, 0, 0, Y, R, 0, 3'd1);
    add(1, 0, 1, 0, 0, R, R, 0, 3'd2);
    add(3, 0, 1, 0, 0, R, G, 1, 3'd3);
    add(2, 0, 1, 0, 0, R, Y, 0, 3'd4);
    add(1, 0, 1, 0, 0, R, R, 0, 3'd5);
    add(5, 0, 1, 0, 0, G, R, 0, 3'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].tk, tbl[i].ss, tbl[i].pr);
      chk($sformatf("vec%0d", i), tbl[i].m, tbl[i].s, tbl[i].w, tbl[i].ph);
    end

    // ped request during side green is served next round
    tick_div = 1;
    do_reset(1, 1'b0);
    tstep(1'b0, 1'b1);
    wait_phase("ped2_reach_sg", 3'd3, 1'b0);
    chk("ped2_walk_sg0", R, G, 1'b1, 3'd3);
    tstep(1'b0, 1'b1);
    chk("ped2_walk_sg1", R, G, 1'b1, 3'd3);
    tstep(1'b0, 1'b0);
    chk("ped2_walk_sg2", R, G, 1'b1, 3'd3);
    tstep(1'b0, 1'b0);
    chk("ped2_side_yellow", R, Y, 1'b0, 3'd4);
    wait_phase("ped2_back_main", 3'd0, 1'b0);
    run_len(3'd0, 1'b0, n);
    chk_int("ped2_main_green_len", n, 4);
    wait_phase("ped2_second_sg", 3'd3, 1'b0);
    chk("ped2_second_walk", R, G, 1'b1, 3'd3);

    // tick every 4th cycle: durations scale by 4
    tick_div = 4;
    do_reset(1, 1'b1);
    wait_phase("slow_reach_my", 3'd1, 1'b1);
    run_len(3'd1, 1'b1, n);
    chk_int("slow_main_yellow_len", n, 8);
    run_len(3'd2, 1'b1, n);
    chk_int("slow_all_red_a_len", n, 4);
    run_len(3'd3, 1'b1, n);
    chk_int("slow_side_green_len", n, 12);
    run_len(3'd4, 1'b1, n);
    chk_int("slow_side_yellow_len", n, 8);
    run_len(3'd5, 1'b1, n);
    chk_int("slow_all_red_b_len", n, 4);
    run_len(3'd0, 1'b1, n);
    chk_int("slow_main_green_len", n, 16);

    // reset pulse in side yellow with a request pending
    tick_div = 1;
    do_reset(1, 1'b1);
    wait_phase("rst_reach_sg", 3'd3, 1'b1);
    tstep(1'b1, 1'b1);
    wait_phase("rst_reach_sy", 3'd4, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    tcnt = 0;
    chk("rst_mid_phase", G, R, 1'b0, 3'd0);
    for (int k = 0; k < 12; k++) begin
      tstep(1'b0, 1'b0);
      chk("rst_pending_cleared", G, R, 1'b0, 3'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
